// File: rtl/ascon_sequencer_if.sv
// Host and core handshake bundle for ascon_sequencer.
// The master modport is the sequencer's view; slave is the host/core environment.
interface ascon_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  i_sys_enable;
    logic                  i_go;
    logic [DATA_WIDTH-1:0] i_host_data;
    logic                  i_host_valid;
    logic                  o_host_ready;
    logic                  i_core_data_req;
    logic                  i_core_valid_cipher;
    logic                  i_core_done;
    logic                  o_core_start;
    logic                  o_core_data_valid;
    logic [DATA_WIDTH-1:0] o_core_data;
    logic                  o_cipher_valid;
    logic [2:0]            o_cipher_index;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;

    modport master (
        input  i_sys_enable, i_go, i_host_data, i_host_valid,
        input  i_core_data_req, i_core_valid_cipher, i_core_done,
        output o_host_ready, o_core_start, o_core_data_valid, o_core_data,
        output o_cipher_valid, o_cipher_index, o_busy, o_done, o_error
    );

    modport slave (
        output i_sys_enable, i_go, i_host_data, i_host_valid,
        output i_core_data_req, i_core_valid_cipher, i_core_done,
        input  o_host_ready, o_core_start, o_core_data_valid, o_core_data,
        input  o_cipher_valid, o_cipher_index, o_busy, o_done, o_error
    );
endinterface

// File: rtl/ascon_sequencer.sv
// Feeds one ASCON-128 message (AD, plaintext blocks, finalization) from a 2-entry host FIFO
// into the core, indexes cipher outputs and trips a watchdog on a hung core.
module ascon_sequencer #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned NUM_PT_BLOCKS = 4,
    parameter int unsigned TIMEOUT       = 32
) (
    input logic           clock,
    input logic           reset_n,
    ascon_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_REQ  = 3'd2;
    localparam logic [2:0] S_PUSH      = 3'd3;
    localparam logic [2:0] S_RELEASE   = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam int unsigned LastWord = NUM_PT_BLOCKS + 2;
    localparam int unsigned WcW      = $clog2(LastWord + 1);

    logic [2:0]            state_q, state_d;
    logic [7:0]            wd_q, wd_d;
    logic [WcW-1:0]        word_cnt_q, word_cnt_d;
    logic [2:0]            cipher_cnt_q, cipher_cnt_d;
    logic                  cipher_valid_q;
    logic [2:0]            cipher_index_q;
    logic [DATA_WIDTH-1:0] core_data_q;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic                  host_ready, push, pop, wd_run, cipher_hit;

    assign host_ready = (fifo_cnt_q != 2'd2) && (state_q != S_ERROR);
    assign push       = bus.i_host_valid && host_ready;
    assign cipher_hit = bus.i_core_valid_cipher &&
                        ((state_q == S_WAIT_REQ) || (state_q == S_PUSH) ||
                         (state_q == S_RELEASE) || (state_q == S_WAIT_DONE));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        wd_run  = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.i_go) state_d = S_START;
            S_START: state_d = S_WAIT_REQ;
            S_WAIT_REQ: begin
                // Request with an empty FIFO is host starvation: no watchdog.
                if (bus.i_core_data_req) begin
                    if (fifo_cnt_q != 2'd0) begin
                        pop     = 1'b1;
                        state_d = S_PUSH;
                    end
                end else begin
                    wd_run = 1'b1;
                end
            end
            S_PUSH: state_d = S_RELEASE;
            S_RELEASE: begin
                if (!bus.i_core_data_req) begin
                    state_d = (word_cnt_q == WcW'(LastWord)) ? S_WAIT_DONE : S_WAIT_REQ;
                end else begin
                    wd_run = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.i_core_done) state_d = S_DONE;
                else                 wd_run  = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
        if (wd_run && (wd_q == 8'(TIMEOUT - 1))) state_d = S_ERROR;
    end

    always_comb begin
        wd_d = 8'd0;
        if ((state_d == state_q) && wd_run) wd_d = wd_q + 8'd1;
    end

    always_comb begin
        word_cnt_d   = word_cnt_q;
        cipher_cnt_d = cipher_cnt_q;
        if ((state_q == S_IDLE) && bus.i_go) begin
            word_cnt_d   = '0;
            cipher_cnt_d = '0;
        end else begin
            if (pop) word_cnt_d = word_cnt_q + WcW'(1);
            if (cipher_hit && (cipher_cnt_q != 3'(NUM_PT_BLOCKS))) begin
                cipher_cnt_d = cipher_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (state_q == S_ERROR) begin
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_host_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            wd_q           <= 8'd0;
            word_cnt_q     <= '0;
            cipher_cnt_q   <= 3'd0;
            cipher_valid_q <= 1'b0;
            cipher_index_q <= 3'd0;
            core_data_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else if (!bus.i_sys_enable) begin
            state_q        <= S_IDLE;
            wd_q           <= 8'd0;
            word_cnt_q     <= '0;
            cipher_cnt_q   <= 3'd0;
            cipher_valid_q <= 1'b0;
            cipher_index_q <= 3'd0;
            core_data_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            word_cnt_q     <= word_cnt_d;
            cipher_cnt_q   <= cipher_cnt_d;
            cipher_valid_q <= cipher_hit;
            if (cipher_hit) cipher_index_q <= cipher_cnt_q;
            if (pop)        core_data_q    <= mem_q[rd_ptr_q];
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

    assign bus.o_host_ready      = host_ready;
    assign bus.o_core_start      = (state_q == S_START);
    assign bus.o_core_data_valid = (state_q == S_PUSH);
    assign bus.o_core_data       = core_data_q;
    assign bus.o_cipher_valid    = cipher_valid_q;
    assign bus.o_cipher_index    = cipher_index_q;
    assign bus.o_busy            = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign bus.o_done            = (state_q == S_DONE);
    assign bus.o_error           = (state_q == S_ERROR);
endmodule

// File: tb/tb_ascon_sequencer.sv
// Directed bench for ascon_sequencer: a behavioural core model and host driver run on the
// falling edge; the main thread sequences scenarios and compares against hand-built words.
module tb_ascon_sequencer;
    localparam int unsigned DW  = 64;
    localparam int unsigned NPT = 4;
    localparam int unsigned TO  = 32;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ascon_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    ascon_sequencer #(
        .DATA_WIDTH   (DW),
        .NUM_PT_BLOCKS(NPT),
        .TIMEOUT      (TO)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Host driver, core model and monitor state.
    int          cyc = 0;
    logic [63:0] host_words[$];
    logic [63:0] exp_words[$];
    int          host_idx = 0;
    bit          host_acc = 0;
    bit          hang = 0, starve_en = 0, gate_en = 0;
    int          starve_cnt = 0, rel_cyc = -1;
    bit          sim_seen = 0, sim_pending = 0;
    logic        sim_ready = 1'b0;
    int          req_timer = 0, done_timer = 0, core_words = 0;
    logic [63:0] got_words[$];
    int          push_cyc[$];
    logic [2:0]  got_idx[$];
    int          done_cnt = 0;

    initial begin
        bit hold;
        bus.i_host_valid        = 1'b0;
        bus.i_host_data         = '0;
        bus.i_core_data_req     = 1'b0;
        bus.i_core_valid_cipher = 1'b0;
        bus.i_core_done         = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (sim_pending) begin
                sim_ready   = bus.o_host_ready;
                sim_pending = 1'b0;
            end
            if (bus.o_core_data_valid) begin
                got_words.push_back(bus.o_core_data);
                push_cyc.push_back(cyc);
            end
            if (bus.o_cipher_valid) got_idx.push_back(bus.o_cipher_index);
            if (bus.o_done) done_cnt++;

            bus.i_core_valid_cipher = 1'b0;
            bus.i_core_done         = 1'b0;
            if (!reset_n || !bus.i_sys_enable) begin
                bus.i_core_data_req = 1'b0;
                req_timer  = 0;
                done_timer = 0;
                core_words = 0;
            end else if (bus.o_core_start) begin
                bus.i_core_data_req = 1'b0;
                core_words = 0;
                req_timer  = hang ? 0 : 12;
            end else if (bus.o_core_data_valid) begin
                bus.i_core_data_req = 1'b0;
                core_words++;
                if (core_words >= 2) bus.i_core_valid_cipher = 1'b1;
                if (core_words == NPT + 2) done_timer = 3;
                else                       req_timer  = 7;
            end else begin
                if (req_timer > 0) begin
                    req_timer--;
                    if (req_timer == 0) bus.i_core_data_req = 1'b1;
                end
                if (done_timer > 0) begin
                    done_timer--;
                    if (done_timer == 0) bus.i_core_done = 1'b1;
                end
            end

            if (host_acc) host_idx++;
            hold = 1'b0;
            if (gate_en && host_idx >= 1 && !bus.i_core_data_req) hold = 1'b1;
            if (starve_en && host_idx == 3 && starve_cnt < 100) begin
                hold = 1'b1;
                if (bus.i_core_data_req) starve_cnt++;
            end
            bus.i_host_valid = (host_idx < host_words.size()) && !hold;
            bus.i_host_data  = bus.i_host_valid ? host_words[host_idx] : '0;
            if (bus.i_host_valid && gate_en && host_idx == 1) begin
                gate_en     = 1'b0;
                sim_seen    = bus.o_host_ready;
                sim_pending = 1'b1;
            end
            if (bus.i_host_valid && starve_en && host_idx == 3 && rel_cyc < 0) rel_cyc = cyc;
            host_acc = bus.i_host_valid && bus.o_host_ready;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {bus.o_core_start, bus.o_core_data_valid, bus.o_cipher_valid,
                bus.o_cipher_index, bus.o_busy, bus.o_done, bus.o_error};
    endfunction

    task automatic clr_tb();
        host_words.delete();
        exp_words.delete();
        got_words.delete();
        push_cyc.delete();
        got_idx.delete();
        host_idx = 0; host_acc = 0; done_cnt = 0;
        hang = 0; starve_en = 0; gate_en = 0; starve_cnt = 0; rel_cyc = -1;
        sim_seen = 0; sim_pending = 0; sim_ready = 1'b0;
    endtask

    task automatic load_msg(input logic [63:0] base, input bit ad_ones);
        for (int k = 0; k < NPT + 2; k++) begin
            logic [63:0] w;
            w = base + 64'(k);
            if (k == 0 && ad_ones) w = 64'h1111_1111_1111_1111;
            exp_words.push_back(w);
        end
        host_words = exp_words;
    endtask

    task automatic go_start(input string tag);
        bus.i_go = 1'b1;
        step();
        bus.i_go = 1'b0;
        check({tag, "_start"}, bus.o_core_start, 1'b1);
    endtask

    task automatic finish_msg(input string tag);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
        check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        step();
        check({tag, "_busy_after"}, bus.o_busy, 1'b0);
        check({tag, "_nwords"}, 64'(got_words.size()), 64'(NPT + 2));
        for (int k = 0; k < NPT + 2; k++) begin
            if (k < got_words.size()) check($sformatf("%s_w%0d", tag, k), got_words[k], exp_words[k]);
        end
        check({tag, "_nidx"}, 64'(got_idx.size()), 64'(NPT + 1));
        for (int k = 0; k < NPT + 1; k++) begin
            if (k < got_idx.size()) check($sformatf("%s_idx%0d", tag, k), got_idx[k], 64'(k));
        end
        check({tag, "_err"}, bus.o_error, 1'b0);
    endtask

    initial begin
        bus.i_sys_enable = 1'b1;
        bus.i_go         = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("rst_outs", outs(), 9'd0);
        check("rst_data", bus.o_core_data, 64'd0);
        check("rst_ready", bus.o_host_ready, 1'b1);

        // Nominal message with two preloaded words filling the FIFO.
        clr_tb();
        load_msg(64'hA000_0000_0000_0000, 1'b1);
        repeat (4) step();
        check("full_ready", bus.o_host_ready, 1'b0);
        go_start("nom");
        finish_msg("nom");

        // One entry held; next word pushed in the same cycle as the AD pop.
        clr_tb();
        gate_en = 1'b1;
        load_msg(64'hB000_0000_0000_0000, 1'b0);
        repeat (4) step();
        check("one_ready", bus.o_host_ready, 1'b1);
        go_start("sim");
        finish_msg("sim");
        check("sim_ready_at_pop", sim_seen, 1'b1);
        check("sim_ready_after", sim_ready, 1'b1);

        // Host starvation on P2.
        clr_tb();
        starve_en = 1'b1;
        load_msg(64'hC000_0000_0000_0000, 1'b0);
        repeat (4) step();
        go_start("stv");
        finish_msg("stv");
        if (push_cyc.size() > 3) check("stv_latency", 64'(push_cyc[3] - rel_cyc), 64'd2);
        else                     check("stv_latency", 64'(push_cyc.size()), 64'd4);

        // Watchdog: core never requests.
        clr_tb();
        hang = 1'b1;
        load_msg(64'hD000_0000_0000_0000, 1'b0);
        repeat (4) step();
        go_start("wd");
        repeat (TO) step();
        check("wd_err_early", bus.o_error, 1'b0);
        step();
        check("wd_err", bus.o_error, 1'b1);
        check("wd_ready", bus.o_host_ready, 1'b0);
        check("wd_busy", bus.o_busy, 1'b0);
        bus.i_sys_enable = 1'b0;
        clr_tb();
        step();
        bus.i_sys_enable = 1'b1;
        check("wd_clr_outs", outs(), 9'd0);
        check("wd_clr_ready", bus.o_host_ready, 1'b1);

        // Abort after the third push, then restart from a clean FIFO.
        load_msg(64'hE000_0000_0000_0000, 1'b0);
        repeat (4) step();
        go_start("abt");
        for (int i = 0; i < 500 && got_words.size() < 3; i++) step();
        check("abt_reached", 64'(got_words.size()), 64'd3);
        bus.i_sys_enable = 1'b0;
        clr_tb();
        step();
        bus.i_sys_enable = 1'b1;
        check("abt_outs", outs(), 9'd0);
        check("abt_data", bus.o_core_data, 64'd0);
        check("abt_ready", bus.o_host_ready, 1'b1);
        load_msg(64'hF000_0000_0000_0000, 1'b0);
        repeat (4) step();
        go_start("rst2");
        finish_msg("rst2");

        // Asynchronous reset while in S_PUSH.
        clr_tb();
        load_msg(64'h5000_0000_0000_0000, 1'b0);
        repeat (4) step();
        go_start("arst");
        for (int i = 0; i < 500 && got_words.size() < 2; i++) step();
        check("arst_in_push", bus.o_core_data_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_outs", outs(), 9'd0);
        check("arst_data", bus.o_core_data, 64'd0);
        clr_tb();
        step();
        reset_n = 1'b1;
        step();
        check("arst_ready", bus.o_host_ready, 1'b1);
        check("arst_idle", outs(), 9'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ascon_sequencer.md
# ascon_sequencer

Host-side scheduler that drives one `ascon_core` (top FSM plus datapath) through a complete ASCON-128 message. It issues the start pulse, then feeds the core exactly one associated-data word, `NUM_PT_BLOCKS` plaintext words and one finalization word, each from a 2-entry host FIFO and each only when the core asks for it. It also indexes the cipher outputs, signals message completion and flags a hung core with a watchdog. It sits between the host bus adapter and the core's `i_start`/`i_data_valid`/data inputs.

## Interface
- `DATA_WIDTH`, 64: width of one host/core data word.
- `NUM_PT_BLOCKS`, 4: plaintext words per message. Must equal the core block-counter terminal count + 1.
- `TIMEOUT`, 32: maximum number of cycles spent waiting on the core before error. Legal range 2..255.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_sys_enable`  in  1  low = synchronous soft clear (same as reset except outputs go to reset values on the next edge).
- `i_go`  in  1  start one message; sampled only in S_IDLE.
- `i_host_data`  in  DATA_WIDTH  host word.
- `i_host_valid`  in  1  host word valid.
- `o_host_ready`  out  1  FIFO can accept a word (= not full and not S_ERROR). Does not depend on the same-cycle pop.
- `i_core_data_req`  in  1  high while the core FSM sits in a data-wait state (AD, PT or finalization idle), decoded at top level.
- `i_core_valid_cipher`  in  1  core cipher-valid pulse.
- `i_core_done`  in  1  core end-of-message pulse.
- `o_core_start`  out  1  one-cycle start to the core.
- `o_core_data_valid`  out  1  one-cycle data valid to the core.
- `o_core_data`  out  DATA_WIDTH  registered word; held until the next push.
- `o_cipher_valid`  out  1  registered echo of `i_core_valid_cipher`.
- `o_cipher_index`  out  3  index of the echoed cipher word: 0..NUM_PT_BLOCKS-1 for plaintext, NUM_PT_BLOCKS for finalization.
- `o_busy`  out  1  high in any state other than S_IDLE and S_ERROR.
- `o_done`  out  1  one-cycle message-complete pulse.
- `o_error`  out  1  sticky watchdog error.

## Operation
- States: S_IDLE, S_START, S_WAIT_REQ, S_PUSH, S_RELEASE, S_WAIT_DONE, S_DONE, S_ERROR.
- **S_IDLE**
  - `i_go` → S_START. This also clears `word_cnt` and `cipher_cnt`.
  - FIFO may be preloaded while in S_IDLE.
- **S_START**: `o_core_start`=1, then → S_WAIT_REQ.
- **S_WAIT_REQ**
  - `i_core_data_req` and FIFO non-empty: pop the FIFO head into `o_core_data`, `word_cnt`++, → S_PUSH.
  - req low: watchdog counts.
  - req high with FIFO empty: wait indefinitely. Host starvation is not an error; the watchdog is held at 0.
- **S_PUSH**: `o_core_data_valid`=1, then → S_RELEASE.
- **S_RELEASE**
  - Wait for `i_core_data_req`=0 (watchdog counts).
  - Then → S_WAIT_DONE if `word_cnt` == NUM_PT_BLOCKS+2, else → S_WAIT_REQ.
- **S_WAIT_DONE**: `i_core_done` → S_DONE. Watchdog counts.
- **S_DONE**: `o_done`=1, then → S_IDLE.
- **Watchdog**
  - 8-bit counter, cleared on every state change.
  - Reaching TIMEOUT in S_WAIT_REQ (req low), S_RELEASE or S_WAIT_DONE → S_ERROR.
- **S_ERROR**
  - `o_error`=1, FIFO flushed, host blocked.
  - Left only by reset or `i_sys_enable`=0, which also sends the core to idle.
- **Cipher index**
  - Each `i_core_valid_cipher`: `o_cipher_valid`=1 next cycle with `o_cipher_index` = `cipher_cnt`, then `cipher_cnt`++.
  - `cipher_cnt` saturates at NUM_PT_BLOCKS.
  - Pulses are ignored outside S_WAIT_REQ/S_PUSH/S_RELEASE/S_WAIT_DONE.
- **FIFO**
  - 2 entries, pointer-based.
  - Simultaneous push and pop when 1 entry is held: allowed, count unchanged.
  - Push when full is impossible (ready low); the host must hold its word.
- **Boundary conditions**
  - `i_go` outside S_IDLE is ignored.
  - `i_core_done` outside S_WAIT_DONE is ignored.
  - `i_sys_enable`=0 mid-message: next edge → S_IDLE with FIFO, counters and all outputs cleared.

## Timing
- Reset values:
  - all outputs 0; `o_core_data` = 0;
  - state S_IDLE; FIFO empty; counters 0.
  - `o_host_ready` = 1 once `reset_n` is high.
- All core-facing outputs are Moore-decoded from registered state, so there is no combinational path from the core.
- `i_go` at cycle t → `o_core_start` at t+1, S_WAIT_REQ at t+2.
- req and FIFO non-empty at t → `o_core_data_valid` and new `o_core_data` at t+1.
- Data stays stable until the next push, so it is valid through the core's START cycle.
- `i_core_valid_cipher` at t → `o_cipher_valid` at t+1.
- `i_core_done` at t → `o_done` at t+1, S_IDLE at t+2.
- Host word accepted at t → earliest push to the core at t+1 (FIFO head registered).
- Watchdog fires when TIMEOUT cycles elapse in a waiting state: error at entry + TIMEOUT.

## Test plan
- **Nominal message.** Preload 2 words, stream 6 words (0x1111…, P0..P3, F). Core model requests 12 cycles after start and 7 cycles after each push. Required:
  - 6 `o_core_data_valid` pulses carrying words in order;
  - `o_cipher_index` sequence 0,1,2,3,4;
  - one `o_done`; then `o_busy`=0.
- **Host starvation.** Host withholds P2 for 100 cycles while req=1. Required: no error, no valid pulse; push occurs 1 cycle after the word arrives.
- **Watchdog.** Core model never raises req after start. Required:
  - `o_error`=1 exactly TIMEOUT cycles after S_WAIT_REQ entry;
  - `o_host_ready`=0; FIFO flushed.
  - Then `i_sys_enable`=0 for 1 cycle → `o_error`=0, S_IDLE.
- **FIFO full / simultaneous.** Hold `i_host_valid` continuously. Required:
  - `o_host_ready`=0 with 2 entries queued;
  - push and pop in the same cycle at 1 entry keeps the count;
  - no word lost or duplicated.
- **Abort mid-message.** `i_sys_enable`=0 after the 3rd push. Required: next cycle all outputs 0, FIFO empty; a new `i_go` restarts with `o_cipher_index` 0.
- **Async reset.** Assert `reset_n` low mid-cycle in S_PUSH. Required: `o_core_data_valid` drops immediately, all outputs 0.
